main_checksum: RTL and testbench
================================

// Module: main_checksum
// PURPOSE
//   Self-contained checksum engine: on start, computes a CRC-32 over a constant
//   internal byte table and returns it on return_port with a one-cycle done pulse.
//   Top-level compute kernel of the generated design; a host/bench starts it once
//   and reads the 32-bit checksum. No data inputs; all data is elaboration-time.
// PARAMETERS
//   NUM_BYTES  9                       number of table bytes hashed (0..64)
//   DATA       72'h393837363534333231  packed table, byte i = DATA[8i+7:8i] ("123456789")
//   POLY       32'hEDB88320            reflected CRC-32 polynomial
// PORTS
//   clock        in   1   single clock, rising-edge
//   reset        in   1   asynchronous, active-high reset
//   start_port   in   1   start request, sampled on rising edge in IDLE
//   done_port    out  1   one-cycle pulse, result valid
//   return_port  out  32  checksum result
// BEHAVIOUR
//   - One clock; reset is asynchronous and active-high. While reset=1: state=IDLE,
//     done_port=0, return_port=0, crc=0, counters=0.
//   - FSM states IDLE, RUN, DONE.
//     IDLE: start_port=1 at edge -> crc<=32'hFFFFFFFF, byte_idx<=0, bit_idx<=0;
//       go RUN (or DONE directly with crc final = 0 if NUM_BYTES==0).
//     RUN: one bit per cycle, LSB-first within each byte, bytes in index order:
//       fb = crc[0] ^ byte[bit_idx]; crc <= (crc>>1) ^ (fb ? POLY : 0).
//       bit_idx 7 -> wraps to 0, byte_idx++. After bit 7 of byte NUM_BYTES-1: go DONE.
//     DONE (one cycle): done_port=1, return_port = crc ^ 32'hFFFFFFFF; next IDLE.
//   - Latency: done_port is high in the cycle following edge S+8*NUM_BYTES+1, where
//     S is the edge sampling start (NUM_BYTES=9 -> 73 cycles; 0 -> 1 cycle).
//   - done_port high for exactly one cycle per start; low otherwise.
//   - return_port registered; holds last result until next DONE or reset. Not
//     cleared on a new start.
//   - start_port ignored in RUN and DONE (no queueing). Held high continuously ->
//     back-to-back runs, restarting from IDLE after each DONE.
//   - Reset asserted mid-RUN: immediate abort, all outputs 0, no done pulse;
//     after release, idle until a fresh start.
//   - Result is deterministic: identical for every run with the same parameters.
//   - All arithmetic 32-bit unsigned, no carries; counters sized for NUM_BYTES=64.
// TESTING
//   - Default params, reset pulse, start 1 cycle -> done after 73 cycles,
//     return_port=32'hCBF43926.
//   - NUM_BYTES=1, DATA[7:0]=8'h61 ("a") -> return_port=32'hE8B7BE43, latency 9.
//   - NUM_BYTES=1, DATA[7:0]=8'h00 -> 32'hD202EF8D; NUM_BYTES=0 -> 32'h00000000
//     with latency 1.
//   - Start pulsed again during RUN -> ignored; exactly one done pulse,
//     value CBF43926.
//   - Reset asserted at cycle 30 of a run -> done_port/return_port 0 at once;
//     new start -> CBF43926 after 73 cycles.
//   - start held high 200 cycles -> done pulses every 74 cycles, each CBF43926.

Source files
------------

// File: rtl/main_checksum.sv
// rtl/main_checksum.sv - bit-serial CRC-32 engine over a constant elaboration-time byte table
// One table bit per RUN cycle; the result is presented with a one-cycle done pulse.
module main_checksum #(
  parameter int          NUM_BYTES = 9,
  parameter logic [511:0] DATA     = 512'h393837363534333231,
  parameter logic [31:0] POLY      = 32'hEDB88320
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start_port,
  output logic        done_port,
  output logic [31:0] return_port
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Index of the final byte; a zero-length table never enters RUN, so 0 is a safe stand-in.
  localparam logic [6:0] LAST_BYTE = 7'((NUM_BYTES > 0) ? NUM_BYTES - 1 : 0);

  state_t      state;
  logic [31:0] crc;
  logic [6:0]  byte_idx;
  logic [2:0]  bit_idx;
  logic        data_bit;
  logic        fb;

  assign data_bit = DATA[{byte_idx[5:0], bit_idx}];
  assign fb       = crc[0] ^ data_bit;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      crc         <= 32'h0;
      byte_idx    <= 7'd0;
      bit_idx     <= 3'd0;
      done_port   <= 1'b0;
      return_port <= 32'h0;
    end else begin
      done_port <= 1'b0;
      case (state)
        IDLE: begin
          if (start_port) begin
            crc      <= 32'hFFFF_FFFF;
            byte_idx <= 7'd0;
            bit_idx  <= 3'd0;
            state    <= (NUM_BYTES == 0) ? DONE : RUN;
          end
        end
        RUN: begin
          crc     <= (crc >> 1) ^ (fb ? POLY : 32'h0);
          bit_idx <= bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
            byte_idx <= byte_idx + 7'd1;
            if (byte_idx == LAST_BYTE) state <= DONE;
          end
        end
        DONE: begin
          done_port   <= 1'b1;
          return_port <= crc ^ 32'hFFFF_FFFF;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_main_checksum.sv
// tb/tb_main_checksum.sv - self-checking bench for main_checksum
// Four instances cover the default table, "a", a zero byte and an empty table.
module tb_main_checksum;

  localparam logic [31:0] POLY = 32'hEDB88320;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start0 = 1'b0, start1 = 1'b0, start2 = 1'b0, start3 = 1'b0;
  logic        done0, done1, done2, done3;
  logic [31:0] ret0, ret1, ret2, ret3;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  main_checksum u0 (
    .clock(clock), .reset(reset), .start_port(start0), .done_port(done0), .return_port(ret0)
  );
  main_checksum #(.NUM_BYTES(1), .DATA(512'h61)) u1 (
    .clock(clock), .reset(reset), .start_port(start1), .done_port(done1), .return_port(ret1)
  );
  main_checksum #(.NUM_BYTES(1), .DATA(512'h00)) u2 (
    .clock(clock), .reset(reset), .start_port(start2), .done_port(done2), .return_port(ret2)
  );
  main_checksum #(.NUM_BYTES(0)) u3 (
    .clock(clock), .reset(reset), .start_port(start3), .done_port(done3), .return_port(ret3)
  );

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Byte-at-a-time table-driven CRC-32, the textbook formulation.
  function automatic logic [31:0] crc_ref(input logic [511:0] d, input int n);
    logic [31:0] tbl [256];
    logic [31:0] c;
    for (int i = 0; i < 256; i++) begin
      c = 32'(i);
      for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ POLY) : (c >> 1);
      tbl[i] = c;
    end
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) c = tbl[(c[7:0] ^ d[8*i +: 8])] ^ (c >> 8);
    return c ^ 32'hFFFF_FFFF;
  endfunction

  // Timing model for u0: a run accepted at edge S completes at edge S + 8*9 + 1.
  logic [31:0] golden0 = 32'h0;
  logic        samp_start = 1'b0;
  logic        samp_rst = 1'b1;
  logic        busy = 1'b0;
  int          remaining = 0;
  logic        exp_done = 1'b0;
  logic [31:0] exp_ret = 32'h0;

  always @(posedge clock) begin
    samp_start <= start0;
    samp_rst   <= reset;
  end

  always @(negedge clock) begin
    if (reset || samp_rst) begin
      busy     = 1'b0;
      exp_done = 1'b0;
      exp_ret  = 32'h0;
    end else begin
      exp_done = 1'b0;
      if (busy) begin
        remaining--;
        if (remaining == 0) begin
          busy     = 1'b0;
          exp_done = 1'b1;
          exp_ret  = golden0;
        end
      end else if (samp_start) begin
        busy      = 1'b1;
        remaining = 8 * 9 + 1;
      end
    end
    check32("model_done0", {31'h0, done0}, {31'h0, exp_done});
    check32("model_ret0", ret0, exp_ret);
  end

  // Pulse start0 once; optionally re-pulse it k cycles into the run.
  task automatic run_main(input int restart_at, output int lat, output int pulses,
                          output logic [31:0] val);
    lat = -1; pulses = 0; val = 32'h0;
    @(posedge clock); #2 start0 = 1'b1;
    @(posedge clock); #2 start0 = 1'b0;
    for (int k = 0; k < 120; k++) begin
      @(negedge clock);
      if (k == restart_at) start0 = 1'b1;
      if (k == restart_at + 1) start0 = 1'b0;
      if (done0) begin
        pulses++;
        if (lat < 0) begin lat = k; val = ret0; end
      end
    end
  endtask

  int          lat, pulses, cnt;
  int          lat1, lat2, lat3, p1, p2, p3;
  int          pos [3];
  logic [31:0] v1, v2, v3, val;

  initial begin
    golden0 = crc_ref(512'h393837363534333231, 9);
    check32("pin_123456789", golden0, 32'hCBF43926);
    check32("pin_a", crc_ref(512'h61, 1), 32'hE8B7BE43);
    check32("pin_zero_byte", crc_ref(512'h00, 1), 32'hD202EF8D);
    check32("pin_empty", crc_ref(512'h393837363534333231, 0), 32'h0);

    repeat (3) @(posedge clock);
    #1;
    check32("reset_done", {31'h0, done0}, 32'h0);
    check32("reset_ret", ret0, 32'h0);
    #1 reset = 1'b0;

    run_main(1000, lat, pulses, val);
    check32("basic_latency", 32'(lat), 32'd73);
    check32("basic_pulses", 32'(pulses), 32'd1);
    check32("basic_value", val, 32'hCBF43926);

    run_main(20, lat, pulses, val);
    check32("restart_ignored_latency", 32'(lat), 32'd73);
    check32("restart_ignored_pulses", 32'(pulses), 32'd1);
    check32("restart_ignored_value", val, 32'hCBF43926);
    check32("ret_held", ret0, 32'hCBF43926);

    // Abort a run with reset 30 cycles in.
    @(posedge clock); #2 start0 = 1'b1;
    @(posedge clock); #2 start0 = 1'b0;
    repeat (30) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check32("abort_done", {31'h0, done0}, 32'h0);
    check32("abort_ret", ret0, 32'h0);
    @(posedge clock); #2 reset = 1'b0;
    cnt = 0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clock);
      if (done0) cnt++;
    end
    check32("abort_no_done", 32'(cnt), 32'd0);
    run_main(1000, lat, pulses, val);
    check32("after_abort_latency", 32'(lat), 32'd73);
    check32("after_abort_value", val, 32'hCBF43926);

    // start held high for 200 edges: back-to-back runs every 74 cycles.
    @(posedge clock); #2 start0 = 1'b1;
    @(posedge clock);
    cnt = 0;
    for (int k = 0; k < 260; k++) begin
      @(negedge clock);
      if (k == 199) start0 = 1'b0;
      if (done0) begin
        if (cnt < 3) pos[cnt] = k;
        cnt++;
        check32("held_value", ret0, 32'hCBF43926);
      end
    end
    check32("held_pulses", 32'(cnt), 32'd3);
    if (cnt >= 3) begin
      check32("held_first", 32'(pos[0]), 32'd73);
      check32("held_gap1", 32'(pos[1] - pos[0]), 32'd74);
      check32("held_gap2", 32'(pos[2] - pos[1]), 32'd74);
    end

    // Alternate tables, all started on the same edge.
    lat1 = -1; lat2 = -1; lat3 = -1; p1 = 0; p2 = 0; p3 = 0;
    v1 = 32'h0; v2 = 32'h0; v3 = 32'h1;
    @(posedge clock); #2 {start1, start2, start3} = 3'b111;
    @(posedge clock); #2 {start1, start2, start3} = 3'b000;
    for (int k = 0; k < 30; k++) begin
      @(negedge clock);
      if (done1) begin p1++; if (lat1 < 0) begin lat1 = k; v1 = ret1; end end
      if (done2) begin p2++; if (lat2 < 0) begin lat2 = k; v2 = ret2; end end
      if (done3) begin p3++; if (lat3 < 0) begin lat3 = k; v3 = ret3; end end
    end
    check32("a_latency", 32'(lat1), 32'd9);
    check32("a_value", v1, 32'hE8B7BE43);
    check32("a_pulses", 32'(p1), 32'd1);
    check32("zero_latency", 32'(lat2), 32'd9);
    check32("zero_value", v2, 32'hD202EF8D);
    check32("empty_latency", 32'(lat3), 32'd1);
    check32("empty_value", v3, 32'h0);
    check32("empty_pulses", 32'(p3), 32'd1);
    check32("a_ret_held", ret1, 32'hE8B7BE43);

    repeat (3) @(posedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
